seq_detect_ctrl: RTL and testbench
==================================

# seq_detect_ctrl

Programmable serial pattern-detection controller for the sequential-circuit library. It holds a configurable PAT_W-bit target pattern (reset value 0; software loads e.g. 1011), arms and disarms detection on command, and shifts qualified serial bits into a history register. It reports one-cycle match pulses, keeps a saturating match count, and signals completion after a programmed number of matches. Overlapping and non-overlapping detection are supported.

## Interface
- PAT_W, 4, pattern length in bits (≥2)
- CNT_W, 8, match counter / target width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- cfg_we  input  1  load config registers (honoured only in IDLE)
- cfg_pattern  input  PAT_W  pattern; MSB is the first bit received
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cfg_target  input  CNT_W  matches required for done; 0 = run until abort
- start  input  1  arm detection (IDLE or DONE only)
- abort  input  1  return to IDLE from any state
- din  input  1  serial data bit
- din_valid  input  1  din is sampled only when this is 1
- busy  output  1  1 in ARMED
- match  output  1  one-cycle pulse per detected pattern
- match_count  output  CNT_W  matches since last start; saturates at all-ones
- done  output  1  level; target reached

## Operation
- States: IDLE, ARMED, DONE. After reset, the state is IDLE.
- Reset values:
  - Outputs: busy=0, match=0, match_count=0, done=0.
  - Internal: history=0, fill=0.
  - Config: pattern=0, overlap=1, target=1.
- cfg_we: in IDLE, all three config registers load on the edge. In ARMED or DONE, cfg_we is ignored and the config is unchanged.
- start:
  - From IDLE or DONE: go to ARMED; clear history, fill, match_count and done.
  - In ARMED: ignored.
- abort: from any state, go to IDLE. done clears and match is forced low. match_count is retained. abort has priority over start and over a same-cycle match.
- ARMED, each edge with din_valid=1:
  - history ← {history[PAT_W-2:0], din}.
  - fill ← min(fill+1, PAT_W).
- Match condition: fill_next == PAT_W and history_next == pattern. When it holds:
  - match=1 for the following cycle.
  - match_count increments, saturating at all-ones.
  - If overlap=0, fill resets to 0, so no bits of the matched window are reused. If overlap=1, fill stays at PAT_W.
- Completion: if target≠0 and the incremented count equals target, the FSM moves to DONE on the same edge. In DONE: done=1, busy=0, and din is ignored.
- Edges with din_valid=0 leave history, fill and state unchanged. match is 0 in the following cycle.

## Timing
- Latency: match, the match_count update, done and the busy fall all become visible on the edge that samples the last pattern bit, i.e. one clock after that bit is presented.
- match is never high for two consecutive cycles unless two consecutive valid bits each complete a match (overlap=1 with a periodic pattern).
- Asserting reset mid-operation forces all reset values immediately, without waiting for clk. Operation resumes on the first clk edge after reset returns to 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold reset=0 mid-stream, with other inputs toggling → busy=0, match=0, match_count=0, done=0 asynchronously. Release reset → state is IDLE.
- **Overlap:** cfg pattern=1011, overlap=1, target=2; start; valid bits 1,0,1,1,0,1,1 → match pulses after bit 4 and after bit 7. match_count=2; done=1 and busy=0 after bit 7.
- **Non-overlap:** same stream with overlap=0, target=3 → single match after bit 4, match_count=1, done=0, busy=1.
- **Valid gaps:** bits 1,0,1,1 with din_valid=0 cycles inserted (din toggling during them) → exactly one match, following the 4th valid bit.
- **Abort / config lock:** abort in ARMED with match_count=1 → IDLE next edge, count stays 1, done=0. Apply cfg_we with pattern=0110 while ARMED → pattern stays 1011.
- **Saturation / target 0:** CNT_W=2, target=0, pattern 1111, overlap=1, ten consecutive 1s → match_count sticks at 3, done never asserts, busy stays 1.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Command, config, serial-data and status bundle for seq_detect_ctrl.
// The master side (software or the bench) drives commands; the slave side is the controller.
interface seq_detect_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             abort;
    logic             din;
    logic             din_valid;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             done;

    modport master (
        output cfg_we, cfg_pattern, cfg_overlap, cfg_target,
        output start, abort, din, din_valid,
        input  busy, match, match_count, done
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_overlap, cfg_target,
        input  start, abort, din, din_valid,
        output busy, match, match_count, done
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: shifts qualified bits into a history window,
// pulses match on each hit, keeps a saturating count and finishes after a target count.
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    seq_detect_ctrl_if.slave bus
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] pattern, pattern_n;
    logic             overlap, overlap_n;
    logic [CNT_W-1:0] target, target_n;
    logic [PAT_W-1:0] history, history_n;
    logic [FW-1:0]    fill, fill_n;
    logic             match, match_n;
    logic [CNT_W-1:0] count, count_n;

    logic [PAT_W-1:0] hist_shift;
    logic [FW-1:0]    fill_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;

    assign hist_shift = {history[PAT_W-2:0], bus.din};
    assign fill_inc   = (fill == FULL) ? FULL : fill + 1'b1;
    assign cnt_inc    = (&count) ? count : count + 1'b1;
    assign hit        = (fill_inc == FULL) && (hist_shift == pattern);

    always_comb begin
        state_n   = state;
        pattern_n = pattern;
        overlap_n = overlap;
        target_n  = target;
        history_n = history;
        fill_n    = fill;
        match_n   = 1'b0;
        count_n   = count;
        // abort outranks start and any same-cycle hit; the count survives it
        if (bus.abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cfg_we) begin
                        pattern_n = bus.cfg_pattern;
                        overlap_n = bus.cfg_overlap;
                        target_n  = bus.cfg_target;
                    end
                    if (bus.start) begin
                        state_n   = ARMED;
                        history_n = '0;
                        fill_n    = '0;
                        count_n   = '0;
                    end
                end
                ARMED: begin
                    if (bus.din_valid) begin
                        history_n = hist_shift;
                        fill_n    = fill_inc;
                        if (hit) begin
                            match_n = 1'b1;
                            count_n = cnt_inc;
                            if (!overlap) fill_n = '0;
                            if ((target != '0) && (cnt_inc == target)) state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state_n   = ARMED;
                        history_n = '0;
                        fill_n    = '0;
                        count_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pattern <= '0;
            overlap <= 1'b1;
            target  <= CNT_W'(1);
            history <= '0;
            fill    <= '0;
            match   <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_n;
            pattern <= pattern_n;
            overlap <= overlap_n;
            target  <= target_n;
            history <= history_n;
            fill    <= fill_n;
            match   <= match_n;
            count   <= count_n;
        end
    end

    assign bus.busy        = (state == ARMED);
    assign bus.done        = (state == DONE);
    assign bus.match       = match;
    assign bus.match_count = count;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboarded random/directed bench for seq_detect_ctrl against a bit-queue reference model.
module tb_seq_detect_ctrl;
    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic             busy;
        logic             match;
        logic [CNT_W-1:0] cnt;
        logic             done;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_detect_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];

    // reference model: bits seen since arm (or since last non-overlapping hit)
    logic [PAT_W-1:0] m_pat;
    logic             m_ovl;
    int               m_tgt;
    int               m_cnt;
    bit               m_armed, m_done;
    bit               m_win[$];

    function automatic obs_t observe();
        obs_t o;
        o.busy  = bus.busy;
        o.match = bus.match;
        o.cnt   = bus.match_count;
        o.done  = bus.done;
        return o;
    endfunction

    task automatic model_reset();
        m_pat = '0; m_ovl = 1'b1; m_tgt = 1; m_cnt = 0;
        m_armed = 0; m_done = 0;
        m_win.delete();
    endtask

    task automatic model_step(input logic we, input logic [PAT_W-1:0] pat, input logic ovl,
                              input int tgt, input logic st, input logic ab,
                              input logic d, input logic dv);
        obs_t e;
        int   v;
        e.match = 1'b0;
        if (ab) begin
            m_armed = 0; m_done = 0;
        end else if (m_armed) begin
            if (dv) begin
                m_win.push_back(d);
                if (m_win.size() > PAT_W) void'(m_win.pop_front());
                v = 0;
                foreach (m_win[i]) v = v * 2 + int'(m_win[i]);
                if (m_win.size() == PAT_W && v == int'(m_pat)) begin
                    e.match = 1'b1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    if (!m_ovl) m_win.delete();
                    if (m_tgt != 0 && m_cnt == m_tgt) begin
                        m_armed = 0; m_done = 1;
                    end
                end
            end
        end else begin
            if (!m_done && we) begin
                m_pat = pat; m_ovl = ovl; m_tgt = tgt;
            end
            if (st) begin
                m_armed = 1; m_done = 0; m_cnt = 0;
                m_win.delete();
            end
        end
        e.busy = m_armed;
        e.done = m_done;
        e.cnt  = CNT_W'(m_cnt);
        exp_q.push_back(e);
    endtask

    // drive one cycle of inputs and record the response expected after the next edge
    task automatic cyc(input logic we, input logic [PAT_W-1:0] pat, input logic ovl,
                       input int tgt, input logic st, input logic ab,
                       input logic d, input logic dv);
        @(negedge clk);
        #1;
        bus.cfg_we = we; bus.cfg_pattern = pat; bus.cfg_overlap = ovl;
        bus.cfg_target = CNT_W'(tgt);
        bus.start = st; bus.abort = ab; bus.din = d; bus.din_valid = dv;
        model_step(we, pat, ovl, tgt, st, ab, d, dv);
    endtask

    task automatic cfg(input logic [PAT_W-1:0] p, input logic o, input int t);
        cyc(1, p, o, t, 0, 0, 1'($urandom), 0);
    endtask
    task automatic arm();   cyc(0, 4'($urandom), 1'($urandom), 0, 1, 0, 1'($urandom), 0); endtask
    task automatic stop();  cyc(0, 4'($urandom), 1'($urandom), 0, 0, 1, 1'($urandom), 0); endtask
    task automatic gap();   cyc(0, 4'($urandom), 1'($urandom), 0, 0, 0, 1'($urandom), 0); endtask
    task automatic bitin(input logic d); cyc(0, 4'($urandom), 1'($urandom), 0, 0, 0, d, 1); endtask

    task automatic check_now(input string name, input obs_t exp);
        obs_t got;
        got = observe();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got busy=%b match=%b cnt=%0d done=%b, want busy=%b match=%b cnt=%0d done=%b",
                     name, got.busy, got.match, got.cnt, got.done, exp.busy, exp.match, exp.cnt, exp.done);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // monitor: outputs are always presented, so one expected record is consumed per edge
    always @(negedge clk) begin
        if (reset && exp_q.size() != 0) begin
            obs_t e, got;
            e   = exp_q.pop_front();
            got = observe();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL out @%0t: got busy=%b match=%b cnt=%0d done=%b, want busy=%b match=%b cnt=%0d done=%b",
                         $time, got.busy, got.match, got.cnt, got.done, e.busy, e.match, e.cnt, e.done);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time budget exhausted");
        $fatal(1, "timeout");
    end

    localparam obs_t ZERO = '0;
    logic [6:0] stream;

    initial begin
        bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_overlap = 0; bus.cfg_target = '0;
        bus.start = 0; bus.abort = 0; bus.din = 0; bus.din_valid = 0;
        model_reset();
        #2;
        check_now("reset_state", ZERO);
        @(negedge clk); #1;
        reset = 1'b1;

        stream = 7'b1011011;
        // overlapping: hits after bits 4 and 7, target 2 reached
        cfg(4'b1011, 1, 2);
        arm();
        for (int i = 6; i >= 0; i--) bitin(stream[i]);
        gap(); gap();
        stop();
        // non-overlapping: a single hit, still armed
        cfg(4'b1011, 0, 3);
        arm();
        for (int i = 6; i >= 0; i--) bitin(stream[i]);
        // config write while armed must not replace 1011
        cfg(4'b0110, 1, 1);
        bitin(0); bitin(1); bitin(1); bitin(0);
        bitin(1); bitin(0); bitin(1); bitin(1);
        stop();
        gap();
        // valid gaps with din toggling in between
        cfg(4'b1011, 1, 0);
        arm();
        bitin(1); gap(); bitin(0); gap(); gap(); bitin(1); gap(); bitin(1); gap(); gap();
        stop();
        // saturation with target 0
        cfg(4'b1111, 1, 0);
        arm();
        for (int i = 0; i < 300; i++) bitin(1);
        // abort colliding with start and a completing bit
        cyc(0, 4'b0000, 0, 0, 1, 1, 1, 1);
        arm();
        drain();

        // asynchronous reset mid-stream
        bitin(1); bitin(1); bitin(1);
        drain();
        #1;
        reset = 1'b0;
        #1;
        check_now("async_reset", ZERO);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            bus.start = 1'($urandom); bus.din = 1'($urandom); bus.din_valid = 1;
            bus.cfg_we = 1; bus.cfg_pattern = 4'($urandom);
            @(negedge clk);
            check_now("held_reset", ZERO);
        end
        @(negedge clk); #1;
        bus.start = 0; bus.cfg_we = 0; bus.din_valid = 0;
        reset = 1'b1;
        model_reset();
        // reset config is pattern 0000, overlap, target 1
        arm();
        bitin(0); bitin(0); bitin(0); bitin(0);
        gap();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            cyc(r < 8, 4'($urandom), 1'($urandom), $urandom_range(0, 5),
                r >= 8 && r < 13, r == 13,
                1'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
